// File: rtl/pe_pkg.sv
// Shared types, default parameters and saturating arithmetic for the bit-serial PE.
package pe_pkg;

  localparam int W_BITS   = 4;
  localparam int A_BITS   = 8;
  localparam int ACC_BITS = 15;
  localparam int N_TERMS  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned add clamped to 2^width-1; operands and width must fit in 31 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return 32'((sum > lim) ? lim : sum);
  endfunction

  function automatic logic sat_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return sum > lim;
  endfunction

endpackage

// File: rtl/pe_shift_add_unit.sv
// Shift-and-add multiplier: latches one operand pair on start and walks the
// weight LSB-first, one bit per cycle. product includes the current bit's term.
module pe_shift_add_unit #(
  parameter int W_BITS = pe_pkg::W_BITS,
  parameter int A_BITS = pe_pkg::A_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [W_BITS-1:0]        weight,
  input  logic [A_BITS-1:0]        act,
  output logic                     last,
  output logic [A_BITS+W_BITS-1:0] product
);

  localparam int P_BITS = A_BITS + W_BITS;
  localparam int IDX_W  = (W_BITS > 1) ? $clog2(W_BITS) : 1;

  logic [W_BITS-1:0] w_q;
  logic [A_BITS-1:0] a_q;
  logic [P_BITS-1:0] prod_q;
  logic [P_BITS-1:0] partial;
  logic [IDX_W-1:0]  bit_idx;
  logic              busy;

  assign partial = w_q[bit_idx] ? (P_BITS'(a_q) << bit_idx) : '0;
  assign product = prod_q + partial;
  assign last    = busy && (bit_idx == IDX_W'(W_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q     <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      w_q     <= weight;
      a_q     <= act;
      prod_q  <= '0;
      bit_idx <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      prod_q  <= product;
      bit_idx <= bit_idx + IDX_W'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_shift_mac.sv
// Bit-serial zero-skip MAC PE: accumulates N_TERMS saturated products per window.
// Build option PE_ZERO_SKIP_EN: zero-operand pairs retire in one cycle and are counted.
//
// state | meaning
// IDLE  | ready for an operand pair (skips zero pairs when enabled)
// MUL   | shift-and-add in progress, one weight bit per cycle
// DONE  | window result presented, waiting for downstream ready
module pe_shift_mac #(
  parameter int W_BITS   = pe_pkg::W_BITS,
  parameter int A_BITS   = pe_pkg::A_BITS,
  parameter int ACC_BITS = pe_pkg::ACC_BITS,
  parameter int N_TERMS  = pe_pkg::N_TERMS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [W_BITS-1:0]            i_weight,
  input  logic [A_BITS-1:0]            i_activation,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [ACC_BITS-1:0]          o_result,
  output logic                         o_sat,
  output logic [$clog2(N_TERMS+1)-1:0] o_skip_cnt
);

  import pe_pkg::*;

  localparam int P_BITS = A_BITS + W_BITS;
  localparam int CNT_W  = $clog2(N_TERMS + 1);

  state_t              state, state_d;
  logic                run_q;
  logic [ACC_BITS-1:0] acc;
  logic                sat_q;
  logic [CNT_W-1:0]    term_cnt;
  logic                start, acc_load, term_inc, win_clr, last_term;
  logic                unit_last;
  logic [P_BITS-1:0]   unit_product;

`ifdef PE_ZERO_SKIP_EN
  logic             skip_inc;
  logic             zero_pair;
  logic [CNT_W-1:0] skip_cnt;
  assign zero_pair = (i_weight == '0) || (i_activation == '0);
`endif

  // run_q holds ready low through reset and for the release cycle
  assign o_in_ready  = run_q && (state == IDLE);
  assign o_out_valid = (state == DONE);
  assign o_result    = acc;
  assign o_sat       = sat_q;
  assign last_term   = (term_cnt == CNT_W'(N_TERMS - 1));

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    acc_load = 1'b0;
    term_inc = 1'b0;
    win_clr  = 1'b0;
`ifdef PE_ZERO_SKIP_EN
    skip_inc = 1'b0;
`endif
    unique case (state)
      IDLE: if (o_in_ready && i_in_valid) begin
`ifdef PE_ZERO_SKIP_EN
        if (zero_pair) begin
          term_inc = 1'b1;
          skip_inc = 1'b1;
          state_d  = last_term ? DONE : IDLE;
        end else begin
          start   = 1'b1;
          state_d = MUL;
        end
`else
        start   = 1'b1;
        state_d = MUL;
`endif
      end
      MUL: if (unit_last) begin
        acc_load = 1'b1;
        term_inc = 1'b1;
        state_d  = last_term ? DONE : IDLE;
      end
      DONE: if (i_out_ready) begin
        win_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      run_q    <= 1'b0;
      acc      <= '0;
      sat_q    <= 1'b0;
      term_cnt <= '0;
    end else begin
      state <= state_d;
      run_q <= 1'b1;
      if (win_clr) begin
        acc      <= '0;
        sat_q    <= 1'b0;
        term_cnt <= '0;
      end else begin
        if (acc_load) begin
          acc   <= ACC_BITS'(sat_add(32'(acc), 32'(unit_product), ACC_BITS));
          sat_q <= sat_q | sat_ovf(32'(acc), 32'(unit_product), ACC_BITS);
        end
        if (term_inc) term_cnt <= term_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PE_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          skip_cnt <= '0;
    else if (win_clr)  skip_cnt <= '0;
    else if (skip_inc) skip_cnt <= skip_cnt + CNT_W'(1);
  end
  assign o_skip_cnt = skip_cnt;
`else
  assign o_skip_cnt = '0;
`endif

  pe_shift_add_unit #(
    .W_BITS(W_BITS),
    .A_BITS(A_BITS)
  ) u_shift_add (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .weight (i_weight),
    .act    (i_activation),
    .last   (unit_last),
    .product(unit_product)
  );

endmodule

// File: doc/pe_shift_mac.md
# pe_shift_mac

Parametrised bit-serial processing element: the next generation of the single-product zero-skip PE in the CNN datapath. It accepts a stream of unsigned (weight, activation) pairs over a valid/ready handshake and multiplies each pair by shift-and-add, one weight bit per cycle. It skips pairs with a zero operand in a single cycle, accumulates N_TERMS products with saturation, and presents one result per window to the downstream adder tree or output buffer.

## Interface
- W_BITS, 4, weight width (unsigned)
- A_BITS, 8, activation width (unsigned)
- ACC_BITS, 15, accumulator/result width; must be ≥ A_BITS+W_BITS
- N_TERMS, 9, products per output window (3x3 kernel); ≥ 1
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_in_valid  input  1  operand pair valid
- o_in_ready  output  1  PE can accept a pair this cycle
- i_weight  input  W_BITS  weight operand
- i_activation  input  A_BITS  activation operand
- o_out_valid  output  1  window result valid
- i_out_ready  input  1  downstream accepts result
- o_result  output  ACC_BITS  saturated sum of N_TERMS products
- o_sat  output  1  saturation occurred in this window
- o_skip_cnt  output  $clog2(N_TERMS+1)  pairs skipped in this window

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE: o_in_ready=1. On i_in_valid:
  - Zero pair (i_weight==0 or i_activation==0): acc unchanged, term_cnt++, skip_cnt++. Stay in IDLE, or go to DONE if this was term N_TERMS-1.
  - Otherwise: latch the operands, clear the product register, set bit_idx=0, go to MUL.
- MUL: o_in_ready=0.
  - Each cycle: product += (weight[bit_idx] ? act << bit_idx : 0), then bit_idx++.
  - On the cycle bit_idx==W_BITS-1: acc = sat(acc + final product), term_cnt++.
  - Then go to IDLE, or to DONE if this was term N_TERMS-1.
- DONE: o_in_ready=0, o_out_valid=1.
  - o_result, o_sat and o_skip_cnt are held stable until i_out_ready.
  - On handshake: acc, term_cnt, skip_cnt and o_sat clear, and the FSM goes to IDLE.
- Arithmetic: product is A_BITS+W_BITS wide and exact. The acc addition is computed at ACC_BITS+1 bits and clamps to 2^ACC_BITS-1 on overflow. o_sat is sticky within the window.
- Inputs are ignored when o_in_ready=0. Operands are sampled only at acceptance.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; acc, product, bit_idx, term_cnt and skip_cnt are 0.
  - Outputs during reset: o_in_ready=0, o_out_valid=0, o_result=0, o_sat=0, o_skip_cnt=0.
  - o_in_ready goes to 1 on the first cycle after release.
- A non-zero pair occupies W_BITS+1 cycles (acceptance + W_BITS MUL cycles). o_in_ready re-asserts the cycle after the last MUL edge.
- A skipped pair occupies 1 cycle. Back-to-back skips are accepted every cycle.
- o_out_valid rises the cycle after the edge that completes term N_TERMS-1.
- Result handshake takes one cycle. The first pair of the next window can be accepted one cycle after the result handshake.
- Reset mid-MUL or mid-DONE aborts the window. No partial result is ever emitted.

## Configuration
- PE_ZERO_SKIP_EN defined: zero-operand pairs take 1 cycle and are counted in o_skip_cnt, as above.
- PE_ZERO_SKIP_EN undefined:
  - Every accepted pair goes through MUL for W_BITS cycles; zero pairs contribute 0.
  - o_skip_cnt is tied to 0.
  - Results are identical; only latency differs.

## Structure
- Shared package pe_pkg holds:
  - the state enum (IDLE/MUL/DONE)
  - the default localparams (W_BITS, A_BITS, ACC_BITS, N_TERMS)
  - a saturating-add function parametrised by width
- One sub-module, pe_shift_add_unit, holds the latched operands, bit_idx and the product register.
  - Inputs: start, weight, act. Outputs: last, product.
  - Top level keeps the FSM, accumulator, counters and handshake.

## Test plan
- Defaults, 9 pairs w=3 a=10 with i_in_valid held high: accepts at cycles 0,5,…,40; o_out_valid rises at cycle 45; o_result=270, o_sat=0, o_skip_cnt=0.
- Defaults, 9 pairs a=0 (macro on): one acceptance per cycle; o_out_valid at cycle 9; o_result=0, o_skip_cnt=9. Same stimulus with the macro off: o_out_valid at cycle 45, o_skip_cnt=0.
- Defaults, 9 pairs w=15 a=255 (9×3825=34425): o_result=32767, o_sat=1.
- Mixed window w/a = {2/7, 0/9, 5/0, 1/1, 4/3, 0/0, 15/2, 8/8, 3/100}: o_result=14+0+0+1+12+0+30+64+300=421, o_skip_cnt=3.
- Backpressure: i_out_ready low for 10 cycles in DONE → o_result, o_sat and o_skip_cnt stable, o_in_ready=0. Raise i_out_ready → next cycle IDLE, and the next window of 9×(1,1) yields 9.
- rst low during the 2nd MUL cycle of term 4 → all outputs 0 immediately. After release, a fresh window of 9×(w=3,a=10) yields 270 with no carry-over.
